// File: rtl/alu_seq_exec_pkg.sv
// Shared op-code and state encodings for the ALU control decoder and the EX-stage unit.
package alu_seq_exec_pkg;

    typedef enum logic [2:0] {
        OpAnd = 3'b000,
        OpOr  = 3'b001,
        OpAdd = 3'b010,
        OpMul = 3'b011,
        OpSub = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } state_e;

    // True for the five codes the decoder can legally emit.
    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            OpAnd, OpOr, OpAdd, OpMul, OpSub: legal = 1'b1;
            default:                          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// Request/response bundle between the pipeline control and the execution unit.
interface alu_seq_exec_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_i;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             kill_i;
    logic             ready_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             err_o;

    modport master (
        output valid_i, ALUCtrl_i, data1_i, data2_i, kill_i,
        input  ready_o, done_o, result_o, zero_o, err_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, data1_i, data2_i, kill_i,
        output ready_o, done_o, result_o, zero_o, err_o
    );
endinterface

// File: rtl/alu_seq_exec_seq_multiplier.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle, WIDTH cycles.
module alu_seq_exec_seq_multiplier #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             kill_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_step;
    logic             last;

    // Partial-product add for the current cycle; the final step's sum is the product.
    always_comb begin
        acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
        last      = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
        done_o    = last && !kill_i;
        product_o = acc_step;
    end

    // Next-state: load on start, otherwise shift one step while busy.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            busy_d   = !(kill_i || last);
        end
    end

    // Datapath and counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// EX-stage execution unit: single-cycle logic/add/sub, multi-cycle multiply, valid/ready/done.
module alu_seq_exec
    import alu_seq_exec_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic           clk_i,
    input logic           rst_i,
    alu_seq_exec_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             ready;
    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] op_res;

    assign ready  = (state_q != StMul);
    assign accept = bus.valid_i && ready;
    assign is_mul = (bus.ALUCtrl_i == OpMul);

    alu_seq_exec_seq_multiplier #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_mul (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (accept && is_mul),
        .kill_i   (bus.kill_i),
        .a_i      (bus.data1_i),
        .b_i      (bus.data2_i),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM next state; kill only matters while multiplying and wins over completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StMul: begin
                if (bus.kill_i)    state_d = StIdle;
                else if (mul_done) state_d = StDone;
            end
            default: begin
                if (accept) state_d = is_mul ? StMul : StDone;
                else        state_d = StIdle;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.ready_o  = ready;
        bus.done_o   = (state_q == StDone);
        bus.result_o = result_q;
        bus.zero_o   = zero_q;
        bus.err_o    = err_q;
    end

    // Result/flag next values: multiply completion or a single-cycle accept.
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        op_res   = '0;
        case (bus.ALUCtrl_i)
            OpAnd:   op_res = bus.data1_i & bus.data2_i;
            OpOr:    op_res = bus.data1_i | bus.data2_i;
            OpAdd:   op_res = bus.data1_i + bus.data2_i;
            OpSub:   op_res = bus.data1_i - bus.data2_i;
            default: op_res = '0;
        endcase
        if (state_q == StMul) begin
            if (mul_done) begin
                result_d = mul_product;
                zero_d   = (mul_product == '0);
                err_d    = 1'b0;
            end
        end else if (accept && !is_mul) begin
            result_d = op_res;
            zero_d   = (op_res == '0);
            err_d    = !is_legal_op(bus.ALUCtrl_i);
        end
    end

    // Output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec: inputs change and outputs are sampled on the falling edge.
module tb_alu_seq_exec;

    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_seq_exec_if #(.WIDTH(WIDTH)) bus ();

    alu_seq_exec #(
        .WIDTH(WIDTH),
        .CNT_W(6)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge and hold it across one rising edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = op;
        bus.data1_i   = a;
        bus.data2_i   = b;
        @(negedge clk);
        bus.valid_i   = 1'b0;
    endtask

    // Advance n cycles, counting any cycle with done_o high.
    task automatic count_done(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done_o) seen++;
        end
    endtask

    initial begin
        int bad;
        int seen;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.valid_i   = 1'b0;
        bus.ALUCtrl_i = 3'b000;
        bus.data1_i   = '0;
        bus.data2_i   = '0;
        bus.kill_i    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", bus.ready_o, 1);
        chk("rst_done", bus.done_o, 0);
        chk("rst_result", bus.result_o, 0);
        chk("rst_zero", bus.zero_o, 1);
        chk("rst_err", bus.err_o, 0);

        // 1: reset in the middle of a multiply.
        issue(3'b000, 32'hF, 32'h3);
        chk("and_pre_done", bus.done_o, 1);
        chk("and_pre_result", bus.result_o, 32'h3);
        @(negedge clk);
        issue(3'b011, 32'd7, 32'd6);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midmul_rst_result", bus.result_o, 0);
        chk("midmul_rst_zero", bus.zero_o, 1);
        chk("midmul_rst_done", bus.done_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.ready_o, 1);
        count_done(40, seen);
        chk("post_rst_no_done", seen, 0);

        // 2: back-to-back single-cycle ops.
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = 3'b010;
        bus.data1_i   = 32'hFFFF_FFFF;
        bus.data2_i   = 32'h1;
        @(negedge clk);
        chk("add_wrap_done", bus.done_o, 1);
        chk("add_wrap_result", bus.result_o, 0);
        chk("add_wrap_zero", bus.zero_o, 1);
        bus.ALUCtrl_i = 3'b110;
        bus.data1_i   = 32'd5;
        bus.data2_i   = 32'd5;
        @(negedge clk);
        chk("sub_b2b_done", bus.done_o, 1);
        chk("sub_b2b_result", bus.result_o, 0);
        chk("sub_b2b_zero", bus.zero_o, 1);
        bus.ALUCtrl_i = 3'b010;
        bus.data1_i   = 32'd3;
        bus.data2_i   = 32'd4;
        @(negedge clk);
        bus.valid_i = 1'b0;
        chk("add_done", bus.done_o, 1);
        chk("add_result", bus.result_o, 7);
        chk("add_zero", bus.zero_o, 0);
        @(negedge clk);
        chk("idle_done_low", bus.done_o, 0);

        // 3: multiply latency and truncation.
        issue(3'b011, 32'd7, 32'd6);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (bus.ready_o || bus.done_o) bad++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", bad, 0);
        chk("mul_done", bus.done_o, 1);
        chk("mul_result", bus.result_o, 42);
        chk("mul_zero", bus.zero_o, 0);
        @(negedge clk);
        chk("mul_done_single", bus.done_o, 0);
        issue(3'b011, 32'h1_0000, 32'h1_0000);
        count_done(32, seen);
        chk("mul_trunc_done", bus.done_o, 1);
        chk("mul_trunc_seen", seen, 1);
        chk("mul_trunc_result", bus.result_o, 0);
        chk("mul_trunc_zero", bus.zero_o, 1);
        @(negedge clk);

        // 4: request held during a multiply, accepted in the DONE cycle.
        issue(3'b011, 32'd3, 32'd5);
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = 3'b001;
        bus.data1_i   = 32'hF0;
        bus.data2_i   = 32'h0F;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (bus.ready_o || bus.done_o) bad++;
            @(negedge clk);
        end
        chk("held_ignored", bad, 0);
        chk("held_mul_done", bus.done_o, 1);
        chk("held_mul_result", bus.result_o, 15);
        @(negedge clk);
        bus.valid_i = 1'b0;
        chk("held_or_done", bus.done_o, 1);
        chk("held_or_result", bus.result_o, 32'hFF);
        @(negedge clk);
        chk("held_or_single", bus.done_o, 0);

        // 5: kill at counter 10 and at the completing edge.
        issue(3'b011, 32'd9, 32'd9);
        repeat (10) @(negedge clk);
        bus.kill_i = 1'b1;
        @(negedge clk);
        bus.kill_i = 1'b0;
        chk("kill10_ready", bus.ready_o, 1);
        chk("kill10_done", bus.done_o, 0);
        chk("kill10_result", bus.result_o, 32'hFF);
        count_done(40, seen);
        chk("kill10_no_done", seen, 0);
        issue(3'b011, 32'd9, 32'd9);
        repeat (31) @(negedge clk);
        bus.kill_i = 1'b1;
        @(negedge clk);
        bus.kill_i = 1'b0;
        chk("kill31_done", bus.done_o, 0);
        chk("kill31_result", bus.result_o, 32'hFF);
        count_done(5, seen);
        chk("kill31_no_done", seen, 0);

        // 6: illegal code, then a legal op (with kill high in IDLE) clears err.
        issue(3'b111, 32'h1234, 32'h5678);
        chk("illegal_done", bus.done_o, 1);
        chk("illegal_err", bus.err_o, 1);
        chk("illegal_result", bus.result_o, 0);
        chk("illegal_zero", bus.zero_o, 1);
        @(negedge clk);
        bus.kill_i = 1'b1;
        issue(3'b000, 32'hC, 32'hA);
        bus.kill_i = 1'b0;
        chk("and_done", bus.done_o, 1);
        chk("and_result", bus.result_o, 32'h8);
        chk("and_err", bus.err_o, 0);
        chk("and_zero", bus.zero_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
Execution unit on the consumer side of the 3-bit ALU control code produced by the ALU control decoder. It performs the operation selected by the code on two operands. AND, OR, ADD and SUB complete in one cycle. MUL runs as an iterative shift-add multiplier. Sits in the EX stage and uses a valid/ready/done handshake so the pipeline can stall on multi-cycle ops.

Parameters:
WIDTH, 32, operand and result width in bits (≥4).
CNT_W, 6, width of the multiply iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
clk_i  input  1  clock, all state updates on rising edge.
rst_i  input  1  reset, asynchronous, active-low.
valid_i  input  1  request present; accepted on a rising edge where valid_i && ready_o.
ALUCtrl_i  input  3  op code: 000 AND, 001 OR, 010 ADD, 110 SUB, 011 MUL; all others illegal.
data1_i  input  WIDTH  operand A; sampled only on accept.
data2_i  input  WIDTH  operand B; sampled only on accept.
kill_i  input  1  synchronous abort of an in-flight MUL.
ready_o  output  1  unit can accept a request this cycle.
done_o  output  1  one-cycle pulse: result_o/zero_o/err_o valid and newly updated.
result_o  output  WIDTH  operation result; holds until the next done_o.
zero_o  output  1  result_o == 0, updated with result_o.
err_o  output  1  last completed request had an illegal code.

Behaviour:
- Reset (rst_i low, any time, including mid-MUL): state=IDLE, counter=0, result_o=0, zero_o=1, err_o=0, done_o=0, ready_o=1 once reset is released. The multiplicand, multiplier and accumulator registers clear to 0.
- States: IDLE, MUL, DONE. ready_o = (state != MUL).
- Accept in IDLE or DONE, non-MUL code, at edge N:
  - result_o, zero_o and err_o are registered at edge N.
  - state moves to DONE, so done_o is high during cycle N+1 (latency 1).
- Accept of a MUL code at edge N:
  - Latch A into the multiplicand, B into the multiplier, clear the accumulator, counter=0, state moves to MUL.
  - Each MUL cycle: if multiplier[0] is set, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter += 1.
  - At the edge where counter == WIDTH-1 (edge N+WIDTH), result_o takes the low WIDTH bits of the final acc and state moves to DONE.
  - done_o is high during cycle N+WIDTH+1. Unsigned; upper product bits are discarded.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH with no carry or overflow output. SUB computes A-B.
- Illegal code: completes like a 1-cycle op with result_o=0, zero_o=1, err_o=1. Any legal completion clears err_o.
- DONE lasts exactly one cycle, then returns to IDLE unless a new accept occurs in DONE, in which case back-to-back requests are allowed. done_o is never high two cycles in a row for a MUL.
- valid_i while in MUL is ignored (ready_o=0). The requester must hold the request until accepted.
- kill_i:
  - In MUL: go to IDLE next edge with no done_o; result_o, zero_o and err_o are unchanged.
  - In IDLE/DONE: ignored, and kill_i does not block an accept in the same cycle.
  - kill_i at the completing MUL edge (counter == WIDTH-1): the kill wins, no result update and no done_o.
- Operands changing after accept have no effect.

Decomposition:
- Shared package holds the op-code constants (AND=000, OR=001, ADD=010, SUB=110, MUL=011) and the state encoding (IDLE, MUL, DONE). The ALU control decoder uses the same package.
- One natural sub-module, seq_multiplier: holds the shift-add datapath and counter, with start/kill/done. The top holds the FSM, the 1-cycle ops and the output registers.

Test Plan:
1. Reset with rst_i low mid-MUL (cycle 5) -> immediately result_o=0, zero_o=1, done_o=0. After release: ready_o=1, and no done_o ever appears for the aborted op.
2. ADD 0xFFFFFFFF+1, then SUB 5-5, back-to-back accepts -> done_o high in consecutive cycles: result 0 with zero_o=1, then 0 with zero_o=1. Then ADD 3+4 -> 7, zero_o=0.
3. MUL 7*6 accepted at edge N -> ready_o=0 for cycles N+1..N+32. done_o is high only in cycle N+33 with result_o=42. Also MUL 0x10000*0x10000 -> 0 with zero_o=1 (truncation).
4. valid_i held with ALUCtrl_i=001 during MUL -> ignored until DONE. It is accepted in the DONE cycle, and done_o follows one cycle later with OR 0xF0|0x0F=0xFF.
5. kill_i asserted at MUL counter 10 -> next cycle IDLE, no done_o, result_o retains its prior value. kill_i exactly at counter 31 -> also no done_o.
6. ALUCtrl_i=111 -> done_o after 1 cycle, err_o=1, result_o=0. Next AND 0xC&0xA -> 0x8, err_o=0.
